// File: rtl/score_n_core.sv
// score_n_core: parametrised connect-N engine keeping cursor, board, turn and win/draw state.
// Define SCORE_N_CURSOR_WRAP_EN to make the cursor wrap around at the board edges instead of saturating.
module score_n_core #(
    parameter int ROWS        = 6,
    parameter int COLS        = 7,
    parameter int WIN_LEN     = 4,
    parameter int CURSOR_INIT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    left,
    input  logic                    right,
    input  logic                    put,
    output logic [$clog2(COLS)-1:0] cursor,
    output logic                    player,
    output logic                    invalid_move,
    output logic                    win_a,
    output logic                    win_b,
    output logic                    full_panel,
    output logic                    busy,
    output logic [2*ROWS*COLS-1:0]  panel
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int NCELL = ROWS * COLS;
    localparam int TW    = $clog2(NCELL + 1);
    localparam int PW    = 2 * NCELL;
    localparam logic [CW-1:0] CUR_MAX  = CW'(COLS - 1);
    localparam logic [CW-1:0] CUR_RST  = CW'(CURSOR_INIT);
    localparam logic [CW-1:0] CUR_ONE  = CW'(1);
    localparam logic [TW-1:0] TOK_FULL = TW'(NCELL);
    localparam logic [TW-1:0] TOK_ONE  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLACE    = 3'd1,
        S_CHECK_H  = 3'd2,
        S_CHECK_V  = 3'd3,
        S_CHECK_D1 = 3'd4,
        S_CHECK_D2 = 3'd5,
        S_OVER     = 3'd6
    } state_t;

    function automatic logic [1:0] cell_at(input logic [PW-1:0] p, input int r, input int c);
        logic [1:0] v;
        v = 2'b00;
        if (r >= 32'sd0 && r < ROWS && c >= 32'sd0 && c < COLS) begin
            v = p[32'sd2 * (r * COLS + c) +: 2];
        end else begin
            v = 2'b00;
        end
        return v;
    endfunction

    // Off-board cells read as empty, so they never extend a run.
    function automatic int run_len(input logic [PW-1:0] p, input int r0, input int c0,
                                   input int dr, input int dc, input logic [1:0] code);
        int   n;
        logic go;
        n  = 32'sd0;
        go = 1'b1;
        for (int k = 32'sd1; k < WIN_LEN; k++) begin
            if (go && (cell_at(p, r0 + k * dr, c0 + k * dc) == code)) begin
                n = n + 32'sd1;
            end else begin
                go = 1'b0;
            end
        end
        return n;
    endfunction

    state_t          state_r, state_s;
    logic            left_q_r, right_q_r, put_q_r;
    logic [CW-1:0]   cursor_r, cursor_s, cur_inc_s, cur_dec_s;
    logic            player_r, player_s, invalid_r, invalid_s;
    logic            win_a_r, win_a_s, win_b_r, win_b_s, full_r, full_s, busy_r, busy_s;
    logic [PW-1:0]   panel_r, panel_s;
    logic [RW-1:0]   row_r, row_s, low_row_s;
    logic [TW-1:0]   tok_r, tok_s;
    logic            hit_r, hit_s, hit_all_s, axis_en_s, axis_hit_s;
    logic            put_e_s, right_e_s, left_e_s, col_full_s;
    logic [1:0]      code_s;
    int              dr_s, dc_s, run_sum_s, place_idx_s;

    // Edge detection with put > right > left priority, plus cursor neighbours.
    always_comb begin
        put_e_s    = put & ~put_q_r;
        right_e_s  = right & ~right_q_r & ~put_e_s;
        left_e_s   = left & ~left_q_r & ~put_e_s & ~right_e_s;
        code_s     = player_r ? 2'b10 : 2'b01;
        col_full_s = (cell_at(panel_r, ROWS - 32'sd1, int'(cursor_r)) != 2'b00);
`ifdef SCORE_N_CURSOR_WRAP_EN
        cur_inc_s  = (cursor_r == CUR_MAX) ? {CW{1'b0}} : cursor_r + CUR_ONE;
        cur_dec_s  = (cursor_r == {CW{1'b0}}) ? CUR_MAX : cursor_r - CUR_ONE;
`else
        cur_inc_s  = (cursor_r == CUR_MAX) ? CUR_MAX : cursor_r + CUR_ONE;
        cur_dec_s  = (cursor_r == {CW{1'b0}}) ? {CW{1'b0}} : cursor_r - CUR_ONE;
`endif
    end

    // Lowest empty row in the cursor column (scan top-down, last empty seen wins).
    always_comb begin
        low_row_s = {RW{1'b0}};
        for (int r = ROWS - 32'sd1; r >= 32'sd0; r--) begin
            if (cell_at(panel_r, r, int'(cursor_r)) == 2'b00) begin
                low_row_s = RW'(r);
            end else begin
                low_row_s = low_row_s;
            end
        end
    end

    // One axis per CHECK state, counted both ways from the placed cell.
    always_comb begin
        dr_s      = 32'sd0;
        dc_s      = 32'sd0;
        axis_en_s = 1'b1;
        case (state_r)
            S_CHECK_H:  dc_s = 32'sd1;
            S_CHECK_V:  dr_s = 32'sd1;
            S_CHECK_D1: begin dr_s = 32'sd1; dc_s = 32'sd1;  end
            S_CHECK_D2: begin dr_s = 32'sd1; dc_s = -32'sd1; end
            default:    axis_en_s = 1'b0;
        endcase
        run_sum_s = run_len(panel_r, int'(row_r), int'(cursor_r), dr_s, dc_s, code_s)
                  + run_len(panel_r, int'(row_r), int'(cursor_r), -dr_s, -dc_s, code_s)
                  + 32'sd1;
        axis_hit_s = axis_en_s && (run_sum_s >= WIN_LEN);
        hit_all_s  = hit_r | axis_hit_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (put_e_s && !col_full_s) state_s = S_PLACE;
                else                        state_s = S_IDLE;
            end
            S_PLACE:    state_s = S_CHECK_H;
            S_CHECK_H:  state_s = S_CHECK_V;
            S_CHECK_V:  state_s = S_CHECK_D1;
            S_CHECK_D1: state_s = S_CHECK_D2;
            S_CHECK_D2: begin
                if (hit_all_s || (tok_r == TOK_FULL)) state_s = S_OVER;
                else                                  state_s = S_IDLE;
            end
            S_OVER:     state_s = S_OVER;
            default:    state_s = S_IDLE;
        endcase
    end

    // Next values of the board, cursor and game flags.
    always_comb begin
        cursor_s    = cursor_r;
        player_s    = player_r;
        invalid_s   = invalid_r;
        win_a_s     = win_a_r;
        win_b_s     = win_b_r;
        full_s      = full_r;
        panel_s     = panel_r;
        row_s       = row_r;
        tok_s       = tok_r;
        hit_s       = hit_r;
        place_idx_s = 32'sd2 * (int'(row_r) * COLS + int'(cursor_r));
        case (state_r)
            S_IDLE: begin
                if (put_e_s) begin
                    if (col_full_s) begin
                        invalid_s = 1'b1;
                    end else begin
                        invalid_s = 1'b0;
                        row_s     = low_row_s;
                        hit_s     = 1'b0;
                    end
                end else if (right_e_s) begin
                    invalid_s = 1'b0;
                    cursor_s  = cur_inc_s;
                end else if (left_e_s) begin
                    invalid_s = 1'b0;
                    cursor_s  = cur_dec_s;
                end else begin
                    invalid_s = invalid_r;
                end
            end
            S_PLACE: begin
                panel_s[place_idx_s +: 2] = code_s;
                tok_s = tok_r + TOK_ONE;
            end
            S_CHECK_H, S_CHECK_V, S_CHECK_D1: hit_s = hit_all_s;
            S_CHECK_D2: begin
                if (hit_all_s) begin
                    win_a_s = ~player_r;
                    win_b_s = player_r;
                end else if (tok_r == TOK_FULL) begin
                    full_s = 1'b1;
                end else begin
                    player_s = ~player_r;
                end
            end
            default: hit_s = hit_r;
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            left_q_r  <= 1'b0;
            right_q_r <= 1'b0;
            put_q_r   <= 1'b0;
            cursor_r  <= CUR_RST;
            player_r  <= 1'b0;
            invalid_r <= 1'b0;
            win_a_r   <= 1'b0;
            win_b_r   <= 1'b0;
            full_r    <= 1'b0;
            busy_r    <= 1'b0;
            panel_r   <= {PW{1'b0}};
            row_r     <= {RW{1'b0}};
            tok_r     <= {TW{1'b0}};
            hit_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            left_q_r  <= left;
            right_q_r <= right;
            put_q_r   <= put;
            cursor_r  <= cursor_s;
            player_r  <= player_s;
            invalid_r <= invalid_s;
            win_a_r   <= win_a_s;
            win_b_r   <= win_b_s;
            full_r    <= full_s;
            busy_r    <= busy_s;
            panel_r   <= panel_s;
            row_r     <= row_s;
            tok_r     <= tok_s;
            hit_r     <= hit_s;
        end
    end

    assign cursor       = cursor_r;
    assign player       = player_r;
    assign invalid_move = invalid_r;
    assign win_a        = win_a_r;
    assign win_b        = win_b_r;
    assign full_panel   = full_r;
    assign busy         = busy_r;
    assign panel        = panel_r;

endmodule
